// File: rtl/csa_accum_ctrl.sv
// Multi-operand accumulator: carry-save accumulation per operand,
// one carry-propagate resolve step, result held until consumed.
module csa_accum_ctrl #(
  parameter int W     = 4,
  parameter int ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       count,
  input  logic             op_valid,
  input  logic [W-1:0]     op_data,
  output logic             op_ready,
  output logic             res_valid,
  output logic [ACC_W-1:0] res_data,
  input  logic             res_ready,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  state_t           state;
  state_t           state_n;
  logic [ACC_W-1:0] s;
  logic [ACC_W-1:0] c;
  logic [ACC_W-1:0] x;
  logic [ACC_W-1:0] s_n;
  logic [ACC_W-1:0] c_n;
  logic [ACC_W-1:0] res;
  logic [3:0]       rem;

  assign x   = ACC_W'(op_data);
  assign s_n = s ^ c ^ x;
  // top carry bit drops out; ACC_W >= W+4 guarantees it is zero
  assign c_n = ((s & c) | (s & x) | (c & x)) << 1;

  assign res_data = res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    op_ready  = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_n = (count != 4'd0) ? ACCUM : RESOLVE;
      end
      ACCUM: begin
        op_ready = 1'b1;
        if (op_valid && rem == 4'd1)
          state_n = RESOLVE;
      end
      RESOLVE: state_n = DONE;
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s   <= '0;
      c   <= '0;
      rem <= '0;
      res <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            s   <= '0;
            c   <= '0;
            rem <= count;
          end
        end
        ACCUM: begin
          if (op_valid) begin
            s   <= s_n;
            c   <= c_n;
            rem <= rem - 4'd1;
          end
        end
        RESOLVE: res <= s + c;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_accum_ctrl.sv
// Self-checking bench for csa_accum_ctrl using a result scoreboard.
module tb_csa_accum_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] count;
  logic       op_valid;
  logic [3:0] op_data;
  logic       op_ready;
  logic       res_valid;
  logic [7:0] res_data;
  logic       res_ready;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [3:0] ops[16];

  csa_accum_ctrl #(.W(4), .ACC_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .count(count),
    .op_valid(op_valid),
    .op_data(op_data),
    .op_ready(op_ready),
    .res_valid(res_valid),
    .res_data(res_data),
    .res_ready(res_ready),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Issue a start at a negedge; returns at the negedge after the start edge.
  task automatic start_job(input int n);
    logic [7:0] sum;
    sum = 8'h00;
    for (int i = 0; i < n; i++) sum = sum + {4'h0, ops[i]};
    exp_q.push_back(sum);
    @(negedge clk);
    start = 1'b1;
    count = 4'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Feed n operands from ops[], gap idle cycles between them.
  task automatic feed(input int n, input int gap, input bit disturb);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (op_ready !== 1'b1) begin
        errors++;
        $display("FAIL feed_ready[%0d]: op_ready=%b required 1", i, op_ready);
      end
      op_valid = 1'b1;
      op_data  = ops[i];
      if (disturb) begin
        start = 1'($urandom);
        count = 4'($urandom);
      end
      @(negedge clk);
      op_valid = 1'b0;
      op_data  = 4'($urandom);
      for (int g = 0; g < gap; g++) begin
        if (disturb) begin
          start = 1'($urandom);
          count = 4'($urandom);
        end
        @(negedge clk);
      end
    end
    start = 1'b0;
  endtask

  // Wait for res_valid (bounded), optionally stall, compare, then handshake.
  task automatic get_result(input string name, input int hold, input bit disturb);
    int         t;
    logic [7:0] exp;
    logic [7:0] first;
    t = 0;
    while (res_valid !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (res_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: res_valid=%b required 1", name, res_valid);
    end
    first = res_data;
    for (int h = 0; h < hold; h++) begin
      if (disturb) begin
        start = 1'($urandom);
        count = 4'($urandom);
      end
      @(negedge clk);
      checks++;
      if (res_valid !== 1'b1 || res_data !== first) begin
        errors++;
        $display("FAIL %s_hold[%0d]: valid=%b data=%h required 1 %h",
                 name, h, res_valid, res_data, first);
      end
    end
    start = 1'b0;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    checks++;
    if (res_data !== exp) begin
      errors++;
      $display("FAIL %s_data: res_data=%h required %h", name, res_data, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== exp) begin
      errors++;
      $display("FAIL %s_post: valid=%b busy=%b data=%h required 0 0 %h",
               name, res_valid, busy, res_data, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #12;
    checks++;
    if ({op_ready, res_valid, busy} !== 3'b000 || res_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_init: ready/valid/busy=%b data=%h required 000 00",
               {op_ready, res_valid, busy}, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_accum;
    for (int i = 0; i < 5; i++) ops[i] = 4'hF;
    start_job(5);
    void'(exp_q.pop_back());
    feed(2, 0, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({op_ready, res_valid, busy} !== 3'b000 || res_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: ready/valid/busy=%b data=%h required 000 00",
               {op_ready, res_valid, busy}, res_data);
    end
    @(negedge clk);
    rst = 1'b0;
    ops[0] = 4'h3;
    start_job(1);
    feed(1, 0, 1'b0);
    get_result("reset_newjob", 0, 1'b0);
  endtask

  task automatic test_basic;
    ops[0] = 4'h5;
    ops[1] = 4'h7;
    ops[2] = 4'h9;
    start_job(3);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: busy=%b required 1", busy);
    end
    feed(3, 0, 1'b0);
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat1: valid=%b busy=%b required 0 1", res_valid, busy);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_lat2: valid=%b busy=%b required 1 1", res_valid, busy);
    end
    get_result("basic", 0, 1'b0);
  endtask

  task automatic test_max_load;
    for (int i = 0; i < 15; i++) ops[i] = 4'hF;
    start_job(15);
    feed(15, 0, 1'b0);
    get_result("maxload", 0, 1'b0);
  endtask

  task automatic test_gaps_backpressure;
    ops[0] = 4'h1;
    ops[1] = 4'h2;
    ops[2] = 4'h4;
    ops[3] = 4'h8;
    start_job(4);
    feed(4, 2, 1'b0);
    get_result("gaps", 5, 1'b0);
  endtask

  task automatic test_zero_len;
    start_job(0);
    checks++;
    if (res_valid !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_e1: valid=%b ready=%b required 0 0", res_valid, op_ready);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1 || op_ready !== 1'b0 || res_data !== 8'h00) begin
      errors++;
      $display("FAIL zero_e2: valid=%b ready=%b data=%h required 1 0 00",
               res_valid, op_ready, res_data);
    end
    get_result("zero", 0, 1'b0);
  endtask

  task automatic test_ignored_controls;
    ops[0] = 4'h3;
    ops[1] = 4'hC;
    ops[2] = 4'h6;
    start_job(3);
    feed(3, 1, 1'b1);
    get_result("ignored", 3, 1'b1);
  endtask

  task automatic test_back_to_back;
    ops[0] = 4'hA;
    ops[1] = 4'h6;
    start_job(2);
    feed(2, 0, 1'b0);
    get_result("b2b", 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      int n;
      n = int'($urandom_range(1, 15));
      for (int i = 0; i < n; i++) ops[i] = 4'($urandom);
      start_job(n);
      feed(n, int'($urandom_range(0, 1)), 1'b0);
      get_result("rand", int'($urandom_range(0, 2)), 1'b0);
    end
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    count     = 4'h0;
    op_valid  = 1'b0;
    op_data   = 4'h0;
    res_ready = 1'b0;
    test_reset();
    test_reset_mid_accum();
    test_basic();
    test_max_load();
    test_gaps_backpressure();
    test_zero_len();
    test_ignored_controls();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
